multicycle_control_unit: RTL and testbench

Multi-cycle MIPS control FSM: sequences each instruction through fetch, decode, execute, memory and write-back over 3–5+ cycles and drives every datapath strobe and mux select per state. It replaces the single-cycle opcode decoder in the multi-cycle core, adds a variable-latency memory handshake (`mem_ready`), optional ADDI support and a sticky illegal-opcode trap. It sits between the instruction register's opcode field and the shared-ALU/shared-memory datapath.

---
 rtl/multicycle_control_unit_pkg.sv | 66 ++++++
 rtl/multicycle_control_unit_if.sv | 40 ++++
 rtl/multicycle_control_unit.sv | 153 +++++++++++++++
 tb/tb_multicycle_control_unit.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/multicycle_control_unit_pkg.sv
// Shared definitions for the multi-cycle MIPS control unit: opcodes, datapath
// mux encodings, the FSM state enum and the bundled control-word struct.
package control_pkg;

   // Opcode field values (instr[31:26])
   localparam logic [5:0] OP_R    = 6'h00;
   localparam logic [5:0] OP_J    = 6'h02;
   localparam logic [5:0] OP_BEQ  = 6'h04;
   localparam logic [5:0] OP_ADDI = 6'h08;
   localparam logic [5:0] OP_LW   = 6'h23;
   localparam logic [5:0] OP_SW   = 6'h2B;

   // ALU operation select
   localparam logic [1:0] ALU_ADD   = 2'b00;
   localparam logic [1:0] ALU_SUB   = 2'b01;
   localparam logic [1:0] ALU_FUNCT = 2'b10;

   // ALU B-operand select
   localparam logic [1:0] SRC_B_REG     = 2'b00;
   localparam logic [1:0] SRC_B_FOUR    = 2'b01;
   localparam logic [1:0] SRC_B_IMM     = 2'b10;
   localparam logic [1:0] SRC_B_IMM_SH2 = 2'b11;

   // Next-PC source select
   localparam logic [1:0] PC_SRC_ALU    = 2'b00;
   localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
   localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

   localparam int STATE_W = 4;

   // FSM states; encodings 13..15 are unused and recover to FETCH
   typedef enum logic [STATE_W-1:0] {
      FETCH     = 4'd0,
      DECODE    = 4'd1,
      MEM_ADDR  = 4'd2,
      MEM_RD    = 4'd3,
      MEM_WB    = 4'd4,
      MEM_WR    = 4'd5,
      R_EXEC    = 4'd6,
      R_WB      = 4'd7,
      BEQ_EXEC  = 4'd8,
      JMP       = 4'd9,
      ADDI_EXEC = 4'd10,
      ADDI_WB   = 4'd11,
      TRAP      = 4'd12
   } state_e;

   // Every datapath strobe and select driven by the controller
   typedef struct packed {
      logic       pc_write;
      logic       pc_write_cond;
      logic       ir_write;
      logic       mem_read;
      logic       mem_write;
      logic       reg_write;
      logic       i_or_d;
      logic       mem_2_reg;
      logic       reg_dst;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] alu_op;
      logic [1:0] pc_source;
      logic       illegal_op;
   } ctrl_t;

endpackage

// File: rtl/multicycle_control_unit_if.sv
// Controller <-> datapath bundle: opcode and memory-ready in, strobes,
// mux selects, trap flag and debug state out.
interface multicycle_control_unit_if;
   import control_pkg::*;

   logic [5:0]         opcode;
   logic               mem_ready;
   logic               pc_write;
   logic               pc_write_cond;
   logic               ir_write;
   logic               mem_read;
   logic               mem_write;
   logic               reg_write;
   logic               i_or_d;
   logic               mem_2_reg;
   logic               reg_dst;
   logic               alu_src_a;
   logic [1:0]         alu_src_b;
   logic [1:0]         alu_op;
   logic [1:0]         pc_source;
   logic               illegal_op;
   logic [STATE_W-1:0] state;

   // Controller side
   modport master (
      input  opcode, mem_ready,
      output pc_write, pc_write_cond, ir_write, mem_read, mem_write,
             reg_write, i_or_d, mem_2_reg, reg_dst, alu_src_a,
             alu_src_b, alu_op, pc_source, illegal_op, state
   );

   // Datapath side
   modport slave (
      output opcode, mem_ready,
      input  pc_write, pc_write_cond, ir_write, mem_read, mem_write,
             reg_write, i_or_d, mem_2_reg, reg_dst, alu_src_a,
             alu_src_b, alu_op, pc_source, illegal_op, state
   );

endinterface

// File: rtl/multicycle_control_unit.sv
// Multi-cycle MIPS control FSM. Steps each instruction through fetch,
// decode, execute, memory and write-back, waiting on mem_ready in the
// memory states when the handshake is enabled. Unknown opcodes (and ADDI
// when not enabled) park the FSM in TRAP until reset.
module multicycle_control_unit
   import control_pkg::*;
#(
   parameter bit ADDI_EN       = 1'b1,
   parameter bit MEM_HANDSHAKE = 1'b1
) (
   input logic                        clk,
   input logic                        rst,
   multicycle_control_unit_if.master  bus
);

   state_e state_q;
   state_e state_d;
   ctrl_t  ctrl;
   logic   ready;

   // Memory access completes this cycle; without the handshake every access is single-cycle
   assign ready = MEM_HANDSHAKE ? bus.mem_ready : 1'b1;

   // State register with synchronous reset back to FETCH
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
      if (rst) state_q <= FETCH;
      else     state_q <= state_d;
   end

   // Next-state and Moore output decode; FETCH strobes also depend on ready
   always_comb begin
      // NOTE: everything assigned here gets a default first, so no path can infer a latch.
      ctrl           = '0;
      ctrl.alu_src_b = SRC_B_REG;
      ctrl.alu_op    = ALU_ADD;
      ctrl.pc_source = PC_SRC_ALU;
      state_d        = state_q;

      case (state_q)
         FETCH: begin
            ctrl.mem_read  = 1'b1;
            ctrl.alu_src_b = SRC_B_FOUR;
            if (ready) begin
               ctrl.ir_write = 1'b1;
               ctrl.pc_write = 1'b1;
               state_d       = DECODE;
            end
         end

         DECODE: begin
            ctrl.alu_src_b = SRC_B_IMM_SH2;
            case (bus.opcode)
               OP_R:         state_d = R_EXEC;
               OP_J:         state_d = JMP;
               OP_BEQ:       state_d = BEQ_EXEC;
               OP_LW, OP_SW: state_d = MEM_ADDR;
               OP_ADDI:      state_d = ADDI_EN ? ADDI_EXEC : TRAP;
               default:      state_d = TRAP;
            endcase
         end

         MEM_ADDR: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_src_b = SRC_B_IMM;
            // Opcode is still held in the IR, so it can be re-examined here
            state_d = (bus.opcode == OP_SW) ? MEM_WR : MEM_RD;
         end

         MEM_RD: begin
            ctrl.mem_read = 1'b1;
            ctrl.i_or_d   = 1'b1;
            if (ready) state_d = MEM_WB;
         end

         MEM_WB: begin
            ctrl.reg_write = 1'b1;
            ctrl.mem_2_reg = 1'b1;
            state_d        = FETCH;
         end

         MEM_WR: begin
            ctrl.mem_write = 1'b1;
            ctrl.i_or_d    = 1'b1;
            if (ready) state_d = FETCH;
         end

         R_EXEC: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_op    = ALU_FUNCT;
            state_d        = R_WB;
         end

         R_WB: begin
            ctrl.reg_write = 1'b1;
            ctrl.reg_dst   = 1'b1;
            state_d        = FETCH;
         end

         BEQ_EXEC: begin
            ctrl.alu_src_a     = 1'b1;
            ctrl.alu_op        = ALU_SUB;
            ctrl.pc_write_cond = 1'b1;
            ctrl.pc_source     = PC_SRC_ALUOUT;
            state_d            = FETCH;
         end

         JMP: begin
            ctrl.pc_write  = 1'b1;
            ctrl.pc_source = PC_SRC_JUMP;
            state_d        = FETCH;
         end

         ADDI_EXEC: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_src_b = SRC_B_IMM;
            state_d        = ADDI_WB;
         end

         ADDI_WB: begin
            ctrl.reg_write = 1'b1;
            state_d        = FETCH;
         end

         TRAP: begin
            ctrl.illegal_op = 1'b1;
            state_d         = TRAP;
         end

         default: state_d = FETCH;
      endcase

      // Nothing is issued in a reset cycle, even mid-instruction
      if (rst) ctrl = '0;
   end

   assign bus.pc_write      = ctrl.pc_write;
   assign bus.pc_write_cond = ctrl.pc_write_cond;
   assign bus.ir_write      = ctrl.ir_write;
   assign bus.mem_read      = ctrl.mem_read;
   assign bus.mem_write     = ctrl.mem_write;
   assign bus.reg_write     = ctrl.reg_write;
   assign bus.i_or_d        = ctrl.i_or_d;
   assign bus.mem_2_reg     = ctrl.mem_2_reg;
   assign bus.reg_dst       = ctrl.reg_dst;
   assign bus.alu_src_a     = ctrl.alu_src_a;
   assign bus.alu_src_b     = ctrl.alu_src_b;
   assign bus.alu_op        = ctrl.alu_op;
   assign bus.pc_source     = ctrl.pc_source;
   assign bus.illegal_op    = ctrl.illegal_op;
   assign bus.state         = rst ? STATE_W'(FETCH) : state_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Randomized bench for multicycle_control_unit. Three instances cover the
// parameter corners (full, ADDI disabled, handshake disabled); each is
// tracked by a per-instruction step-list model and compared every cycle.
module tb_multicycle_control_unit;
   import control_pkg::*;

   localparam int N      = 3;
   localparam int CYCLES = 3000;

   // Observed/expected output word
   typedef struct packed {
      logic [3:0] state;
      logic       illegal_op;
      logic [1:0] pc_source;
      logic [1:0] alu_op;
      logic [1:0] alu_src_b;
      logic       alu_src_a;
      logic       reg_dst;
      logic       mem_2_reg;
      logic       i_or_d;
      logic       reg_write;
      logic       mem_write;
      logic       mem_read;
      logic       ir_write;
      logic       pc_write_cond;
      logic       pc_write;
   } vec_t;

   logic       clk = 1'b0;
   logic       rst;
   logic [5:0] opcode_v [N];
   logic       ready_v  [N];
   vec_t       obs      [N];

   bit addi_en_c [N] = '{1'b1, 1'b0, 1'b1};
   bit hs_c      [N] = '{1'b1, 1'b1, 1'b0};

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   genvar g;
   generate
      for (g = 0; g < N; g++) begin : gen_dut
         multicycle_control_unit_if bus ();
         assign bus.opcode    = opcode_v[g];
         assign bus.mem_ready = ready_v[g];
         assign obs[g] = {bus.state, bus.illegal_op, bus.pc_source, bus.alu_op,
                          bus.alu_src_b, bus.alu_src_a, bus.reg_dst, bus.mem_2_reg,
                          bus.i_or_d, bus.reg_write, bus.mem_write, bus.mem_read,
                          bus.ir_write, bus.pc_write_cond, bus.pc_write};
         multicycle_control_unit #(
            .ADDI_EN       (g != 1),
            .MEM_HANDSHAKE (g != 2)
         ) dut (
            .clk (clk),
            .rst (rst),
            .bus (bus.master)
         );
      end
   endgenerate

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_cmp++;
      if (got !== want) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, want);
      end
   endtask

   // Outputs the controller must show in a given step of an instruction
   function automatic vec_t expect_vec(input int step, input bit rdy);
      vec_t v = '0;
      v.state = 4'(step);
      case (step)
         0:  begin v.mem_read = 1; v.alu_src_b = 2'b01;
                   if (rdy) begin v.ir_write = 1; v.pc_write = 1; end end
         1:  v.alu_src_b = 2'b11;
         2:  begin v.alu_src_a = 1; v.alu_src_b = 2'b10; end
         3:  begin v.mem_read = 1; v.i_or_d = 1; end
         4:  begin v.reg_write = 1; v.mem_2_reg = 1; end
         5:  begin v.mem_write = 1; v.i_or_d = 1; end
         6:  begin v.alu_src_a = 1; v.alu_op = 2'b10; end
         7:  begin v.reg_write = 1; v.reg_dst = 1; end
         8:  begin v.alu_src_a = 1; v.alu_op = 2'b01; v.pc_write_cond = 1; v.pc_source = 2'b01; end
         9:  begin v.pc_write = 1; v.pc_source = 2'b10; end
         10: begin v.alu_src_a = 1; v.alu_src_b = 2'b10; end
         11: v.reg_write = 1;
         12: v.illegal_op = 1;
         default: v = '0;
      endcase
      return v;
   endfunction

   // Remaining steps of the current instruction (head = current step)
   int         plan    [N][$];
   logic [5:0] held_op [N];

   function automatic logic [5:0] pick_op();
      logic [5:0] tab [6] = '{6'h00, 6'h02, 6'h04, 6'h08, 6'h23, 6'h2B};
      if ($urandom_range(0, 11) == 0) return 6'($urandom_range(0, 63));
      return tab[$urandom_range(0, 5)];
   endfunction

   initial begin
      int   step [N];
      bit   eff_rdy;
      vec_t want;

      rst = 1'b1;
      for (int i = 0; i < N; i++) begin
         opcode_v[i] = '0;
         ready_v[i]  = 1'b1;
         held_op[i]  = '0;
         plan[i]     = {};
      end

      for (int cyc = 0; cyc < CYCLES; cyc++) begin
         @(negedge clk);
         rst = (cyc < 2) || ($urandom_range(0, 59) == 0);
         for (int i = 0; i < N; i++) begin
            step[i] = (plan[i].size() != 0) ? plan[i][0] : -1;
            ready_v[i] = ($urandom_range(0, 9) < 6);
            if (step[i] == 1) begin
               held_op[i]  = pick_op();
               opcode_v[i] = held_op[i];
            end else if (step[i] == 2) begin
               opcode_v[i] = held_op[i];
            end else begin
               opcode_v[i] = 6'($urandom_range(0, 63));
            end
         end

         #1;
         for (int i = 0; i < N; i++) begin
            eff_rdy = hs_c[i] ? ready_v[i] : 1'b1;
            want = rst ? vec_t'('0) : expect_vec(step[i], eff_rdy);
            check($sformatf("dut%0d cyc%0d step%0d", i, cyc, step[i]), 32'(obs[i]), 32'(want));

            // Advance the model across the coming clock edge
            if (rst) begin
               plan[i] = {0};
            end else begin
               case (step[i])
                  0: if (eff_rdy) plan[i] = {1};
                  1: begin
                     void'(plan[i].pop_front());
                     case (held_op[i])
                        6'h00: plan[i] = {6, 7};
                        6'h02: plan[i] = {9};
                        6'h04: plan[i] = {8};
                        6'h23: plan[i] = {2, 3, 4};
                        6'h2B: plan[i] = {2, 5};
                        6'h08: plan[i] = addi_en_c[i] ? '{10, 11} : '{12};
                        default: plan[i] = {12};
                     endcase
                  end
                  3, 5: if (eff_rdy) void'(plan[i].pop_front());
                  12: ;
                  default: void'(plan[i].pop_front());
               endcase
               if (plan[i].size() == 0) plan[i].push_back(0);
            end
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
